// File: rtl/input_register_pkg.sv
// Shared constants and types for the decimal entry port: keypad codes,
// entry FSM encoding and the digit-classification helper.
package input_register_pkg;

    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hE;
    localparam int         CNT_W         = 2;

    typedef enum logic {
        ST_ENTRY   = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/input_register_if.sv
// Keypad / control-unit / display bundle for the input register.
// The master side is the system around the port; the slave side is the port itself.
interface input_register_if #(
    parameter int DIGITS = 3,
    parameter int DATA_W = 8
);
    import input_register_pkg::*;

    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  in_en;
    logic [DATA_W-1:0]     bus_out;
    logic                  bus_drive;
    logic [4*DIGITS-1:0]   entry_bcd;
    logic [CNT_W-1:0]      digit_cnt;
    logic                  busy;
    logic                  data_ready;
    logic                  overflow;

    modport master (
        output key_valid, key_code, in_en,
        input  bus_out, bus_drive, entry_bcd, digit_cnt, busy, data_ready, overflow
    );

    modport slave (
        input  key_valid, key_code, in_en,
        output bus_out, bus_drive, entry_bcd, digit_cnt, busy, data_ready, overflow
    );

endinterface

// File: rtl/input_register_bcd_to_bin_serial.sv
// Serial BCD-to-binary converter (reverse double-dabble): one shift-and-correct
// step per cycle for 4*DIGITS cycles; done and bin_out are valid on the final step.
module bcd_to_bin_serial #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                done,
    output logic [4*DIGITS-1:0] bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TC_W  = $clog2(BCD_W);
    localparam logic [TC_W-1:0] LAST = TC_W'(BCD_W - 1);

    logic              active_q;
    logic [TC_W-1:0]   tc_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bin_q;
    logic [2*BCD_W-1:0] shifted;
    logic [BCD_W-1:0]  bcd_nx;
    logic [BCD_W-1:0]  bin_nx;
    logic [3:0]        nib;

    assign shifted = {bcd_q, bin_q} >> 1;
    assign bin_nx  = shifted[BCD_W-1:0];

    // A nibble that received a 1 from above is worth 8 + x but should be 5 + x.
    always_comb begin
        bcd_nx = '0;
        nib    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = shifted[BCD_W + 4*i +: 4];
            bcd_nx[4*i +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            active_q <= 1'b0;
            tc_q     <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            tc_q     <= LAST;
            bcd_q    <= bcd_in;
            bin_q    <= '0;
        end else if (active_q) begin
            bcd_q <= bcd_nx;
            bin_q <= bin_nx;
            if (tc_q == '0) begin
                active_q <= 1'b0;
            end else begin
                tc_q <= tc_q - TC_W'(1);
            end
        end
    end

    assign done    = active_q && (tc_q == '0);
    assign bin_out = bin_nx;

endmodule

// File: rtl/input_register.sv
// Decimal entry port: collects keypad digits, converts them serially to binary
// and holds the saturated result for the CPU bus.
//   state      | meaning
//   ST_ENTRY   | accepting digit / backspace / enter keys
//   ST_CONVERT | serial conversion running, keys dropped
module input_register
    import input_register_pkg::*;
#(
    parameter int          DIGITS    = 3,
    parameter int          DATA_W    = 8,
    parameter int unsigned MAX_VALUE = 255
) (
    input  logic          clk,
    input  logic          clear_n,
    input_register_if.slave port
);

    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q;
    state_t             state_nx;
    logic               start;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bin;
    logic [BCD_W-1:0]   entry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  held_q;
    logic               ready_q;
    logic               ovf_q;
    logic               key_digit;
    logic               key_bs;
    logic               key_enter;
    logic               over;

    assign key_digit = port.key_valid && is_digit(port.key_code);
    assign key_bs    = port.key_valid && (port.key_code == KEY_BACKSPACE);
    assign key_enter = port.key_valid && (port.key_code == KEY_ENTER);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_ENTRY;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        start    = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (key_enter) begin
                    start    = 1'b1;
                    state_nx = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_nx = ST_ENTRY;
                end
            end
            default: state_nx = ST_ENTRY;
        endcase
    end

    bcd_to_bin_serial #(
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start),
        .bcd_in  (entry_q),
        .done    (conv_done),
        .bin_out (conv_bin)
    );

    // Entry buffer: full buffer ignores further digits rather than shifting out.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == ST_CONVERT) begin
            if (conv_done) begin
                entry_q <= '0;
                cnt_q   <= '0;
            end
        end else if (key_digit) begin
            if (32'(cnt_q) < 32'(DIGITS)) begin
                entry_q <= {entry_q[BCD_W-5:0], port.key_code};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end else if (key_bs) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end
    end

    assign over = (32'(conv_bin) > MAX_VALUE);

    // Completion outranks a same-edge bus read so a fresh value is never lost.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            held_q  <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (conv_done) begin
            held_q  <= over ? DATA_W'(MAX_VALUE) : DATA_W'(conv_bin);
            ovf_q   <= over;
            ready_q <= 1'b1;
        end else if (port.in_en) begin
            ready_q <= 1'b0;
        end
    end

    assign port.bus_out    = port.in_en ? held_q : '0;
    assign port.bus_drive  = port.in_en;
    assign port.entry_bcd  = entry_q;
    assign port.digit_cnt  = cnt_q;
    assign port.busy       = (state_q == ST_CONVERT);
    assign port.data_ready = ready_q;
    assign port.overflow   = ovf_q;

endmodule

// File: tb/tb_input_register.sv
// Bench for input_register: decimal-value reference model compared every cycle,
// plus directed keypad sequences with literal expectations.
module tb_input_register;

    localparam int DIGITS    = 3;
    localparam int DATA_W    = 8;
    localparam int MAX_VALUE = 255;
    localparam int CONV_CYC  = 4 * DIGITS;

    logic clk     = 1'b0;
    logic clear_n = 1'b0;
    bit   run     = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    input_register_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) ifc ();

    input_register #(
        .DIGITS    (DIGITS),
        .DATA_W    (DATA_W),
        .MAX_VALUE (MAX_VALUE)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .port    (ifc)
    );

    // Reference model: digits as a list, value as a plain decimal number.
    int m_d[DIGITS];
    int m_n     = 0;
    int m_held  = 0;
    int m_val   = 0;
    int m_timer = 0;
    bit m_busy  = 0;
    bit m_ready = 0;
    bit m_ovf   = 0;
    bit m_fin;

    function automatic int exp_entry();
        int e = 0;
        for (int i = 0; i < m_n; i++) e = e * 16 + m_d[i];
        return e;
    endfunction

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_n = 0; m_held = 0; m_val = 0; m_timer = 0;
            m_busy = 0; m_ready = 0; m_ovf = 0;
        end else begin
            m_fin = 0;
            if (m_busy) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_fin   = 1;
                    m_busy  = 0;
                    m_ovf   = (m_val > MAX_VALUE);
                    m_held  = m_ovf ? MAX_VALUE : m_val;
                    m_ready = 1;
                    m_n     = 0;
                end
            end else if (ifc.key_valid) begin
                if (ifc.key_code <= 4'd9) begin
                    if (m_n < DIGITS) begin
                        m_d[m_n] = int'(ifc.key_code);
                        m_n++;
                    end
                end else if (ifc.key_code == 4'hA) begin
                    m_n = 0;
                end else if (ifc.key_code == 4'hE) begin
                    m_val = 0;
                    for (int i = 0; i < m_n; i++) m_val = m_val * 10 + m_d[i];
                    m_busy  = 1;
                    m_timer = CONV_CYC;
                end
            end
            if (ifc.in_en && !m_fin) m_ready = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("m_bus_out",    32'(ifc.bus_out),    ifc.in_en ? 32'(m_held) : 32'd0);
            chk("m_bus_drive",  32'(ifc.bus_drive),  32'(ifc.in_en));
            chk("m_entry_bcd",  32'(ifc.entry_bcd),  32'(exp_entry()));
            chk("m_digit_cnt",  32'(ifc.digit_cnt),  32'(m_n));
            chk("m_busy",       32'(ifc.busy),       32'(m_busy));
            chk("m_data_ready", 32'(ifc.data_ready), 32'(m_ready));
            chk("m_overflow",   32'(ifc.overflow),   32'(m_ovf));
        end
    end

    task automatic press(input logic [3:0] c);
        ifc.key_valid = 1'b1;
        ifc.key_code  = c;
        @(posedge clk); #1;
        ifc.key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_bus(input string name, input int exp);
        ifc.in_en = 1'b1;
        #1;
        chk(name, 32'(ifc.bus_out), 32'(exp));
        @(posedge clk); #1;
        ifc.in_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.key_valid = 1'b0;
        ifc.key_code  = 4'h0;
        ifc.in_en     = 1'b0;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;

        chk("rst_entry", 32'(ifc.entry_bcd),  32'd0);
        chk("rst_ready", 32'(ifc.data_ready), 32'd0);
        chk("rst_busy",  32'(ifc.busy),       32'd0);

        // 1,2,8 -> 128
        press(4'd1); press(4'd2); press(4'd8);
        chk("entry_128", 32'(ifc.entry_bcd), 32'h128);
        press(4'hE);
        idle(CONV_CYC - 1);
        chk("busy_last_cycle", 32'(ifc.busy), 32'd1);
        chk("not_ready_yet",   32'(ifc.data_ready), 32'd0);
        idle(1);
        chk("ready_128", 32'(ifc.data_ready), 32'd1);
        chk("busy_done", 32'(ifc.busy), 32'd0);
        read_bus("bus_128", 8'h80);
        chk("read_clear", 32'(ifc.data_ready), 32'd0);

        // 300 saturates, then 07 -> 7 clears overflow
        press(4'd3); press(4'd0); press(4'd0); press(4'hE);
        idle(CONV_CYC);
        chk("ovf_set", 32'(ifc.overflow), 32'd1);
        read_bus("bus_sat", 255);
        press(4'd0); press(4'd7); press(4'hE);
        idle(CONV_CYC);
        chk("ovf_clear", 32'(ifc.overflow), 32'd0);
        read_bus("bus_7", 7);

        // fourth digit ignored, backspace clears
        press(4'd4); press(4'd5); press(4'd6); press(4'd7);
        chk("entry_456", 32'(ifc.entry_bcd), 32'h456);
        chk("cnt_full",  32'(ifc.digit_cnt), 32'd3);
        press(4'hA);
        chk("bs_entry", 32'(ifc.entry_bcd), 32'd0);
        chk("bs_cnt",   32'(ifc.digit_cnt), 32'd0);

        // enter with no digits converts 0
        press(4'hE);
        idle(CONV_CYC);
        chk("ready_zero", 32'(ifc.data_ready), 32'd1);
        read_bus("bus_zero", 0);

        // bus read on the completion edge: completion wins
        press(4'd5); press(4'd0); press(4'hE);
        idle(CONV_CYC - 1);
        ifc.in_en = 1'b1;
        @(posedge clk); #1;
        chk("collide_ready", 32'(ifc.data_ready), 32'd1);
        chk("collide_bus",   32'(ifc.bus_out), 32'd50);
        ifc.in_en = 1'b0;
        read_bus("bus_50", 50);
        chk("ready_after_read", 32'(ifc.data_ready), 32'd0);

        // keys during conversion are dropped
        press(4'd2); press(4'hE);
        press(4'd9); press(4'hA); press(4'hE);
        idle(CONV_CYC - 3);
        chk("drop_ready", 32'(ifc.data_ready), 32'd1);
        chk("drop_entry", 32'(ifc.entry_bcd), 32'd0);
        chk("drop_busy",  32'(ifc.busy), 32'd0);

        // async clear mid-conversion, held value 2 must vanish
        press(4'd1); press(4'd0); press(4'd0); press(4'hE);
        idle(5);
        clear_n = 1'b0;
        #1;
        chk("clr_busy",  32'(ifc.busy), 32'd0);
        chk("clr_ready", 32'(ifc.data_ready), 32'd0);
        chk("clr_entry", 32'(ifc.entry_bcd), 32'd0);
        @(posedge clk); #1;
        clear_n = 1'b1;
        read_bus("clr_bus", 0);
        idle(CONV_CYC);
        chk("clr_no_partial", 32'(ifc.data_ready), 32'd0);
        press(4'd9); press(4'hE);
        idle(CONV_CYC);
        chk("ready_9", 32'(ifc.data_ready), 32'd1);
        read_bus("bus_9", 9);

        idle(2);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
